// File: rtl/alu_stage_mc.sv
// Handshaked ALU stage: single-cycle arith/logic/shift and an iterative multiplier.
// Optional macro ALU_DIV_EN adds an iterative unsigned divider (quotient/remainder).
module alu_stage_mc #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       ctrl_in,
   input  logic [WIDTH-1:0] pc_in,
   input  logic [WIDTH-1:0] x_in,
   input  logic [WIDTH-1:0] z_in,
   input  logic [WIDTH-1:0] y_in,
   input  logic [WIDTH-1:0] imm_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z_out,
   output logic             alu_zero,
   output logic             ovfl,
   output logic             busy
);

   localparam int unsigned SHW = $clog2(WIDTH);
   localparam int unsigned CW  = SHW + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

   state_t           r_state;
   logic             r_busy;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_z;
   logic             r_zero;
   logic             r_ovfl;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_opa;
   logic [WIDTH-1:0] r_opb;
   logic [CW-1:0]    r_count;

   logic [1:0]       w_srcx;
   logic [1:0]       w_srcy;
   logic [1:0]       w_fn;
   logic [1:0]       w_fntype;
   logic [WIDTH-1:0] w_x;
   logic [WIDTH-1:0] w_y;
   logic [WIDTH-1:0] w_yop;
   logic [SHW-1:0]   w_shamt;
   logic [WIDTH-1:0] w_res;
   logic             w_ovfl;
   logic             w_multi;
   logic             w_free;
   logic             w_fire;
   logic [WIDTH-1:0] w_mc_res;
   logic [WIDTH-1:0] w_prod_nxt;

   assign w_srcx   = ctrl_in[7:6];
   assign w_srcy   = ctrl_in[5:4];
   assign w_fn     = ctrl_in[3:2];
   assign w_fntype = ctrl_in[1:0];
   assign w_shamt  = w_y[SHW-1:0];

   assign w_free   = ~r_out_valid | out_ready;
   assign in_ready = (r_state == ST_IDLE) & w_free;
   assign w_fire   = in_valid & in_ready;

   assign out_valid = r_out_valid;
   assign z_out     = r_z;
   assign alu_zero  = r_zero;
   assign ovfl      = r_ovfl;
   assign busy      = r_busy;

   // Operand source selection
   always_comb begin
      w_x = '0;
      case (w_srcx)
         2'b00:   w_x = pc_in;
         2'b01:   w_x = x_in;
         2'b10:   w_x = z_in;
         default: w_x = '0;
      endcase
      w_y = WIDTH'(4);
      case (w_srcy)
         2'b00:   w_y = WIDTH'(4);
         2'b01:   w_y = y_in;
         2'b10:   w_y = imm_in;
         default: w_y = {imm_in[WIDTH-3:0], 2'b00};
      endcase
   end

`ifdef ALU_DIV_EN
   typedef enum logic [1:0] {MC_MUL, MC_QUO, MC_REM} mc_op_t;
   mc_op_t         r_mc_op;
   logic [WIDTH:0] w_rsh;
   logic           w_ge;
   logic [WIDTH-1:0] w_rdiff;

   // Restoring divide step: shift next dividend bit into the partial remainder
   assign w_rsh   = {r_acc, r_opa[WIDTH-1]};
   assign w_ge    = (w_rsh >= {1'b0, r_opb});
   assign w_rdiff = w_rsh[WIDTH-1:0] - r_opb;
   assign w_multi = (w_fntype == 2'b11) && (w_fn != 2'b11);

   always_comb begin
      w_mc_res = r_acc;
      if (r_mc_op == MC_QUO) w_mc_res = r_opa;
   end
`else
   assign w_multi  = (w_fntype == 2'b11) && (w_fn == 2'b00);
   assign w_mc_res = r_acc;
`endif

   assign w_prod_nxt = r_acc + (r_opb[0] ? r_opa : '0);

   // Single-cycle result and overflow
   always_comb begin
      w_res  = '0;
      w_ovfl = 1'b0;
      w_yop  = w_fn[0] ? ~w_y : w_y;
      case (w_fntype)
         2'b00: begin
            w_res  = w_x + w_yop + WIDTH'(w_fn[0]);
            w_ovfl = (w_x[WIDTH-1] == w_yop[WIDTH-1]) && (w_res[WIDTH-1] != w_x[WIDTH-1]);
         end
         2'b01: begin
            case (w_fn)
               2'b00:   w_res = w_x & w_y;
               2'b01:   w_res = w_x | w_y;
               2'b10:   w_res = w_x ^ w_y;
               default: w_res = ~(w_x | w_y);
            endcase
         end
         2'b10: begin
            case (w_fn)
               // shift by WIDTH yields 0, so a zero amount rotates cleanly
               2'b00:   w_res = (w_x >> w_shamt) | (w_x << (CW'(WIDTH) - {1'b0, w_shamt}));
               2'b01:   w_res = w_x >> w_shamt;
               2'b10:   w_res = w_x << w_shamt;
               default: w_res = $unsigned($signed(w_x) >>> w_shamt);
            endcase
         end
         default: w_res = '0;
      endcase
   end

   // Control FSM, iterative datapath and output register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_busy      <= 1'b0;
         r_out_valid <= 1'b0;
         r_z         <= '0;
         r_zero      <= 1'b0;
         r_ovfl      <= 1'b0;
         r_acc       <= '0;
         r_opa       <= '0;
         r_opb       <= '0;
         r_count     <= '0;
`ifdef ALU_DIV_EN
         r_mc_op     <= MC_MUL;
`endif
      end else begin
         if (r_out_valid && out_ready) r_out_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_fire) begin
                  if (w_multi) begin
                     r_state <= ST_BUSY;
                     r_busy  <= 1'b1;
                     r_acc   <= '0;
                     r_opa   <= w_x;
                     r_opb   <= w_y;
                     r_count <= CW'(WIDTH);
`ifdef ALU_DIV_EN
                     r_mc_op <= (w_fn == 2'b00) ? MC_MUL : ((w_fn == 2'b01) ? MC_QUO : MC_REM);
`endif
                  end else begin
                     r_z         <= w_res;
                     r_zero      <= (w_res == '0);
                     r_ovfl      <= w_ovfl;
                     r_out_valid <= 1'b1;
                  end
               end
            end
            ST_BUSY: begin
`ifdef ALU_DIV_EN
               if (r_mc_op == MC_MUL) begin
                  r_acc <= w_prod_nxt;
                  r_opa <= r_opa << 1;
                  r_opb <= r_opb >> 1;
               end else begin
                  r_acc <= w_ge ? w_rdiff : w_rsh[WIDTH-1:0];
                  r_opa <= {r_opa[WIDTH-2:0], w_ge};
               end
`else
               r_acc <= w_prod_nxt;
               r_opa <= r_opa << 1;
               r_opb <= r_opb >> 1;
`endif
               r_count <= r_count - CW'(1);
               if (r_count == CW'(1)) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
               end
            end
            ST_DONE: begin
               if (w_free) begin
                  r_z         <= w_mc_res;
                  r_zero      <= (w_mc_res == '0);
                  r_ovfl      <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_stage_mc.sv
// Directed bench for alu_stage_mc (WIDTH=32): vector table plus multi-cycle sequences.
module tb_alu_stage_mc;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  ctrl_in;
   logic [31:0] pc_in, x_in, z_in, y_in, imm_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] z_out;
   logic        alu_zero;
   logic        ovfl;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   alu_stage_mc #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .ctrl_in(ctrl_in),
      .pc_in(pc_in), .x_in(x_in), .z_in(z_in), .y_in(y_in), .imm_in(imm_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .z_out(z_out), .alu_zero(alu_zero), .ovfl(ovfl), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  ctrl;
      logic [31:0] pc, x, z, y, imm;
      logic [31:0] ez;
      logic        ezero;
      logic        eovfl;
   } vec_t;

   function automatic vec_t mk(input logic [7:0] c, input logic [31:0] pc, input logic [31:0] x,
                               input logic [31:0] z, input logic [31:0] y, input logic [31:0] imm,
                               input logic [31:0] ez, input logic ezero, input logic eovfl);
      vec_t v;
      v.ctrl = c; v.pc = pc; v.x = x; v.z = z; v.y = y; v.imm = imm;
      v.ez = ez; v.ezero = ezero; v.eovfl = eovfl;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic set_op(input logic [7:0] c, input logic [31:0] pc, input logic [31:0] x,
                         input logic [31:0] z, input logic [31:0] y, input logic [31:0] imm);
      ctrl_in = c; pc_in = pc; x_in = x; z_in = z; y_in = y; imm_in = imm;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue a multi-cycle op and check latency and result
   task automatic run_mc(input string nm, input logic [7:0] c, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] ez);
      int cyc;
      set_op(c, 32'h0, x, 32'h0, y, 32'h0);
      in_valid = 1'b1;
      chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 100) begin
         tick();
         cyc++;
      end
      chk({nm, "_latency"}, 32'(cyc), 32'd33);
      chk({nm, "_z"}, z_out, ez);
      chk({nm, "_zero"}, 32'(alu_zero), 32'(ez == 32'h0));
      chk({nm, "_ovfl"}, 32'(ovfl), 32'd0);
      tick();
   endtask

   vec_t tv[22];

   initial begin
      int bad;
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      set_op(8'h00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

      tv[0]  = mk(8'h50, 32'h0,    32'h7FFFFFFF, 32'h0,   32'h1,        32'h0,        32'h80000000, 1'b0, 1'b1);
      tv[1]  = mk(8'h54, 32'h0,    32'h5,        32'h0,   32'h5,        32'h0,        32'h0,        1'b1, 1'b0);
      tv[2]  = mk(8'h50, 32'h0,    32'h80000000, 32'h0,   32'h80000000, 32'h0,        32'h0,        1'b1, 1'b1);
      tv[3]  = mk(8'h54, 32'h0,    32'h80000000, 32'h0,   32'h1,        32'h0,        32'h7FFFFFFF, 1'b0, 1'b1);
      tv[4]  = mk(8'h30, 32'h1000, 32'h0,        32'h0,   32'h0,        32'h3,        32'h0000100C, 1'b0, 1'b0);
      tv[5]  = mk(8'h00, 32'h1000, 32'h0,        32'h0,   32'h0,        32'h3,        32'h00001004, 1'b0, 1'b0);
      tv[6]  = mk(8'h52, 32'h0,    32'h80000001, 32'h0,   32'h4,        32'h0,        32'h18000000, 1'b0, 1'b0);
      tv[7]  = mk(8'h56, 32'h0,    32'h80000001, 32'h0,   32'h4,        32'h0,        32'h08000000, 1'b0, 1'b0);
      tv[8]  = mk(8'h5A, 32'h0,    32'h80000001, 32'h0,   32'h4,        32'h0,        32'h00000010, 1'b0, 1'b0);
      tv[9]  = mk(8'h5E, 32'h0,    32'h80000001, 32'h0,   32'h4,        32'h0,        32'hF8000000, 1'b0, 1'b0);
      tv[10] = mk(8'h52, 32'h0,    32'h80000001, 32'h0,   32'd32,       32'h0,        32'h80000001, 1'b0, 1'b0);
      tv[11] = mk(8'h5E, 32'h0,    32'h80000001, 32'h0,   32'd32,       32'h0,        32'h80000001, 1'b0, 1'b0);
      tv[12] = mk(8'h5A, 32'h0,    32'h1,        32'h0,   32'h1F,       32'h0,        32'h80000000, 1'b0, 1'b0);
      tv[13] = mk(8'h51, 32'h0,    32'hF0F0,     32'h0,   32'hFF00,     32'h0,        32'h0000F000, 1'b0, 1'b0);
      tv[14] = mk(8'h55, 32'h0,    32'hF0F0,     32'h0,   32'hFF00,     32'h0,        32'h0000FFF0, 1'b0, 1'b0);
      tv[15] = mk(8'h59, 32'h0,    32'hF0F0,     32'h0,   32'hFF00,     32'h0,        32'h00000FF0, 1'b0, 1'b0);
      tv[16] = mk(8'h5D, 32'h0,    32'hF0F0F0F0, 32'h0,   32'h0F0F0000, 32'h0,        32'h00000F0F, 1'b0, 1'b0);
      tv[17] = mk(8'h59, 32'h0,    32'hFFFFFFFF, 32'h0,   32'hFFFFFFFF, 32'h0,        32'h0,        1'b1, 1'b0);
      tv[18] = mk(8'hA0, 32'h0,    32'h0,        32'h100, 32'h0,        32'h20,       32'h00000120, 1'b0, 1'b0);
      tv[19] = mk(8'hD4, 32'h0,    32'h12345678, 32'h0,   32'h1,        32'h0,        32'hFFFFFFFF, 1'b0, 1'b0);
      tv[20] = mk(8'hF0, 32'h0,    32'h0,        32'h0,   32'h0,        32'hC0000001, 32'h00000004, 1'b0, 1'b0);
      tv[21] = mk(8'h5F, 32'h0,    32'h5,        32'h0,   32'h5,        32'h0,        32'h0,        1'b1, 1'b0);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_z_out", z_out, 32'h0);
      chk("rst_zero", 32'(alu_zero), 32'd0);
      chk("rst_ovfl", 32'(ovfl), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      tick();

      // Back-to-back single-cycle vectors
      in_valid = 1'b1;
      for (int i = 0; i < 22; i++) begin
         set_op(tv[i].ctrl, tv[i].pc, tv[i].x, tv[i].z, tv[i].y, tv[i].imm);
         chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
         tick();
         chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("vec%0d_z", i), z_out, tv[i].ez);
         chk($sformatf("vec%0d_zero", i), 32'(alu_zero), 32'(tv[i].ezero));
         chk($sformatf("vec%0d_ovfl", i), 32'(ovfl), 32'(tv[i].eovfl));
      end
      in_valid = 1'b0;
      tick();
      chk("drain_valid", 32'(out_valid), 32'd0);

      // Back-pressure, then consume and accept in the same cycle
      out_ready = 1'b0;
      set_op(8'h51, 32'h0, 32'h0F, 32'h0, 32'hFF, 32'h0);
      in_valid = 1'b1;
      tick();
      chk("bp_and_valid", 32'(out_valid), 32'd1);
      chk("bp_and_z", z_out, 32'h0F);
      set_op(8'h55, 32'h0, 32'hF0, 32'h0, 32'h01, 32'h0);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      repeat (3) tick();
      chk("bp_hold_z", z_out, 32'h0F);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      #1;
      chk("bp_in_ready_high", 32'(in_ready), 32'd1);
      tick();
      chk("bp_or_z", z_out, 32'hF1);
      chk("bp_or_valid", 32'(out_valid), 32'd1);
      in_valid = 1'b0;
      tick();
      chk("bp_consumed", 32'(out_valid), 32'd0);

      // Multiply with a new request held during BUSY
      set_op(8'h53, 32'h0, 32'h0000FFFF, 32'h0, 32'h00010001, 32'h0);
      in_valid = 1'b1;
      chk("mul_accept_ready", 32'(in_ready), 32'd1);
      tick();
      set_op(8'h50, 32'h0, 32'h2, 32'h0, 32'h3, 32'h0);
      bad = 0;
      for (int i = 0; i < 32; i++) begin
         if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
         tick();
      end
      chk("mul_busy_window_bad_cycles", 32'(bad), 32'd0);
      chk("mul_done_busy", 32'(busy), 32'd0);
      chk("mul_done_valid", 32'(out_valid), 32'd0);
      tick();
      chk("mul_valid_at_33", 32'(out_valid), 32'd1);
      chk("mul_z", z_out, 32'hFFFFFFFF);
      chk("mul_zero", 32'(alu_zero), 32'd0);
      tick();
      chk("post_mul_add_z", z_out, 32'h5);
      in_valid = 1'b0;
      tick();

      run_mc("mul_wrap", 8'h53, 32'h00012345, 32'h00010000, 32'h23450000);
      run_mc("mul_zero_res", 8'h53, 32'h00010000, 32'h00010000, 32'h0);

`ifdef ALU_DIV_EN
      run_mc("div_quo", 8'h57, 32'd100, 32'd7, 32'd14);
      run_mc("div_rem", 8'h5B, 32'd100, 32'd7, 32'd2);
      run_mc("div0_quo", 8'h57, 32'h1234, 32'd0, 32'hFFFFFFFF);
      run_mc("div0_rem", 8'h5B, 32'h1234, 32'd0, 32'h1234);
`else
      set_op(8'h57, 32'h0, 32'd100, 32'h0, 32'd7, 32'h0);
      in_valid = 1'b1;
      tick();
      chk("nodiv_quo_z", z_out, 32'h0);
      chk("nodiv_quo_zero", 32'(alu_zero), 32'd1);
      chk("nodiv_quo_busy", 32'(busy), 32'd0);
      set_op(8'h5B, 32'h0, 32'd100, 32'h0, 32'd7, 32'h0);
      tick();
      chk("nodiv_rem_valid", 32'(out_valid), 32'd1);
      chk("nodiv_rem_z", z_out, 32'h0);
      in_valid = 1'b0;
      tick();
`endif

      // Reset during BUSY aborts the multiply
      set_op(8'h53, 32'h0, 32'h0000FFFF, 32'h0, 32'h00010001, 32'h0);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (10) tick();
      chk("abort_busy_before", 32'(busy), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_valid", 32'(out_valid), 32'd0);
      chk("abort_z", z_out, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
      end
      chk("abort_no_output", 32'(bad), 32'd0);
      set_op(8'h50, 32'h0, 32'd2, 32'h0, 32'd3, 32'h0);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("after_reset_add_valid", 32'(out_valid), 32'd1);
      chk("after_reset_add_z", z_out, 32'd5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_stage_mc.md
Name: alu_stage_mc

Overview:
Parametrised, handshaked successor to the stage-3 ALU. It accepts one operation per transaction and selects X/Y operands from PC, register, forwarded-Z, immediate and offset sources. Arithmetic, logic and shift operations complete in a single cycle. An iterative shift-add multiplier runs for WIDTH cycles. The result and flags are held in an output register until the downstream stage consumes them.

Parameters:
WIDTH, 32, datapath width in bits; must be a power of two, 8..64
SHW, $clog2(WIDTH), shift-amount width; derived, not overridden

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous reset, active-low (asserted at 0)
in_valid  in  1  operation request valid
in_ready  out  1  stage can accept an operation this cycle
ctrl_in  in  8  [7:6] SRCX, [5:4] SRCY, [3:2] FN, [1:0] FNTYPE
pc_in  in  WIDTH  X source 00
x_in  in  WIDTH  X source 01
z_in  in  WIDTH  X source 10 (forwarded result)
y_in  in  WIDTH  Y source 01
imm_in  in  WIDTH  Y source 10; source 11 is imm_in<<2
out_valid  out  1  result register valid
out_ready  in  1  downstream accepts the result
z_out  out  WIDTH  result
alu_zero  out  1  z_out == 0
ovfl  out  1  signed overflow (add/sub only)
busy  out  1  multiplier iterating

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; out_valid=0, z_out=0, alu_zero=0, ovfl=0, busy=0. Reset applied mid-multiply aborts the operation with no output.
- Operand selection on acceptance:
  - X mux: SRCX 00=pc_in, 01=x_in, 10=z_in, 11=0.
  - Y mux: SRCY 00=constant 4, 01=y_in, 10=imm_in, 11={imm_in[WIDTH-3:0],2'b00}.
  - Operands are captured into internal registers on acceptance; inputs may change afterwards.
- Function selection:
  - FNTYPE 00 arith: FN[0]=0 add, FN[0]=1 sub (x + ~y + 1). FN[1] ignored. ovfl = signed overflow.
  - FNTYPE 01 logic: FN 00 AND, 01 OR, 10 XOR, 11 NOR.
  - FNTYPE 10 shift of X by Y[SHW-1:0]: FN 00 rotate-right, 01 SRL, 10 SLL, 11 SRA. Shift amount 0 passes X through.
  - FNTYPE 11 FN 00 multiply: unsigned, low WIDTH bits of X*Y.
- ovfl=0 for every non-arith operation. alu_zero is computed from the final result for every operation.
- Handshake:
  - Acceptance = in_valid & in_ready.
  - in_ready = (state==IDLE) & (~out_valid | out_ready).
  - out_valid stays 1 and z_out/flags stay stable until out_valid & out_ready.
  - Simultaneous consume and accept in one cycle is allowed; the new result replaces the old one.
- States:
  - IDLE: a single-cycle op accepted at edge N loads the result register; out_valid=1 after edge N (latency 1, throughput 1/cycle). A multiply accepted goes to BUSY with product=0, mcand=X, mplier=Y, count=WIDTH.
  - BUSY (busy=1, in_ready=0): each cycle, if mplier[0] then product += mcand (mod 2^WIDTH); mcand <<= 1; mplier >>= 1; count--. When count reaches 0, go to DONE.
  - DONE: if the output register is free (~out_valid or out_ready), load the product, set out_valid=1 and go to IDLE. Otherwise stall in DONE.
  - Multiply latency is WIDTH+1 cycles from acceptance to out_valid when there is no back-pressure.
- Wrap-around: add/sub/mul results are modulo 2^WIDTH. Y source 11 drops imm_in's top two bits.
- in_valid while busy is ignored; upstream must hold it.

Optional Feature:
ALU_DIV_EN:
- When defined, FNTYPE 11 with FN 01 gives the unsigned quotient and FN 10 gives the unsigned remainder.
- The divider is a restoring divider that reuses the BUSY/DONE path, with the same WIDTH+1 latency.
- Divide by zero returns quotient all-ones and remainder = X; no flag is raised.
- When ALU_DIV_EN is undefined, FNTYPE 11 with FN 01, 10 or 11 completes in one cycle with z_out=0 and alu_zero=1.
- With the feature on, FN 11 under FNTYPE 11 also returns 0.

Test Plan:
- WIDTH=32, out_ready=1: SRCX=01, SRCY=01, x=0x7FFFFFFF, y=1, add → next cycle z_out=0x80000000, ovfl=1, alu_zero=0. Then sub with x=5, y=5 → z_out=0, alu_zero=1, ovfl=0.
- SRCX=00 pc=0x1000, SRCY=11 imm=0x3 add → z_out=0x100C. SRCY=00 → z_out=0x1004.
- Shifts with x=0x80000001, y=4: ROT → 0x18000000, SRL → 0x08000000, SLL → 0x00000010, SRA → 0xF8000000. y=32 (shamt 0) → 0x80000001.
- Multiply x=0xFFFF, y=0x10001 → busy=1 and in_ready=0 for 32 cycles, out_valid asserted 33 cycles after acceptance, z_out=0xFFFFFFFF. A new in_valid during busy is not accepted.
- Back-pressure: out_ready=0 after an AND result 0x0F → z_out holds 0x0F, in_ready=0. Raising out_ready with a new OR request pending → consume and accept in the same cycle, next z_out = OR result.
- Assert reset=0 at BUSY cycle 10 → out_valid=0, busy=0 immediately. After release, a fresh add 2+3 → z_out=5. With ALU_DIV_EN: 100/7 → quotient 14, remainder 2; x/0 → 0xFFFFFFFF.
